// File: rtl/npc_ctrl_pkg.sv
// Shared definitions for the NPC execution sequencer: FSM states, opcode
// constants and the opcode decode that decides whether an instruction writes rd.
package npc_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT,
        EXEC,
        HALT
    } npc_state_e;

    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_IMM   = 7'b0010011;

    localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
    localparam logic [31:0] INST_NOP    = 32'h0000_0013;

    // Only the instruction classes the datapath supports write the register file.
    function automatic logic npc_writes_rd(input logic [31:0] inst);
        case (inst[6:0])
            OP_JAL, OP_JALR, OP_AUIPC, OP_LUI, OP_IMM: return 1'b1;
            default:                                   return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/npc_exec_ctrl.sv
// Multi-cycle fetch/execute sequencer for the single-cycle NPC datapath.
// All outputs are registered; the FSM next state is computed in one always_comb.
module npc_exec_ctrl
    import npc_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC       = 32'h8000_0000,
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned CNT_W          = 32
) (
    input  logic             clk,
    input  logic             rst,
    output logic             ifu_req_valid,
    input  logic             ifu_req_ready,
    output logic [31:0]      ifu_addr,
    input  logic             ifu_resp_valid,
    input  logic [31:0]      ifu_rdata,
    output logic [31:0]      instruction,
    output logic [31:0]      pc,
    input  logic [31:0]      next_pc,
    output logic             wen,
    output logic             halt,
    output logic             fault,
    output logic [CNT_W-1:0] retire_cnt
);

    localparam logic [31:0] TIMER_LAST = TIMEOUT_CYCLES - 32'd1;

    npc_state_e       state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      instr_q, instr_d;
    logic             req_valid_q, req_valid_d;
    logic             wen_q, wen_d;
    logic             halt_q, halt_d;
    logic             fault_q, fault_d;
    logic [CNT_W-1:0] retire_q, retire_d;
    logic [31:0]      timer_q, timer_d;

    // wen is registered on the WAIT->EXEC transition so it is high exactly
    // during the EXEC cycle; req_valid is only raised for an aligned target.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        instr_d     = instr_q;
        req_valid_d = req_valid_q;
        wen_d       = 1'b0;
        halt_d      = halt_q;
        fault_d     = fault_q;
        retire_d    = retire_q;
        timer_d     = timer_q;

        case (state_q)
            IDLE: begin
                req_valid_d = (pc_q[1:0] == 2'b00);
                state_d     = FETCH;
            end
            FETCH: begin
                if (pc_q[1:0] != 2'b00) begin
                    req_valid_d = 1'b0;
                    halt_d      = 1'b1;
                    fault_d     = 1'b1;
                    state_d     = HALT;
                end else if (ifu_req_ready) begin
                    req_valid_d = 1'b0;
                    timer_d     = '0;
                    state_d     = WAIT;
                end
            end
            WAIT: begin
                if (ifu_resp_valid) begin
                    instr_d = ifu_rdata;
                    wen_d   = npc_writes_rd(ifu_rdata) && (ifu_rdata != INST_EBREAK);
                    state_d = EXEC;
                end else if ((TIMEOUT_CYCLES != 0) && (timer_q == TIMER_LAST)) begin
                    halt_d  = 1'b1;
                    fault_d = 1'b1;
                    state_d = HALT;
                end else begin
                    timer_d = timer_q + 32'd1;
                end
            end
            EXEC: begin
                retire_d = retire_q + CNT_W'(1);
                if (instr_q == INST_EBREAK) begin
                    halt_d  = 1'b1;
                    state_d = HALT;
                end else begin
                    pc_d        = next_pc;
                    req_valid_d = (next_pc[1:0] == 2'b00);
                    state_d     = FETCH;
                end
            end
            HALT: begin
                req_valid_d = 1'b0;
            end
            default: begin
                req_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            pc_q        <= RESET_PC;
            instr_q     <= INST_NOP;
            req_valid_q <= 1'b0;
            wen_q       <= 1'b0;
            halt_q      <= 1'b0;
            fault_q     <= 1'b0;
            retire_q    <= '0;
            timer_q     <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            instr_q     <= instr_d;
            req_valid_q <= req_valid_d;
            wen_q       <= wen_d;
            halt_q      <= halt_d;
            fault_q     <= fault_d;
            retire_q    <= retire_d;
            timer_q     <= timer_d;
        end
    end

    assign ifu_req_valid = req_valid_q;
    assign ifu_addr      = pc_q;
    assign instruction   = instr_q;
    assign pc            = pc_q;
    assign wen           = wen_q;
    assign halt          = halt_q;
    assign fault         = fault_q;
    assign retire_cnt    = retire_q;

endmodule

// File: tb/tb_npc_exec_ctrl.sv
// Self-checking bench for npc_exec_ctrl: a memory responder feeds instructions and
// pushes expected commit results to a scoreboard that a commit monitor pops.
module tb_npc_exec_ctrl;

    localparam logic [31:0] RESET_PC = 32'h8000_0000;
    localparam logic [31:0] W_ADDI   = 32'h0010_0093;
    localparam logic [31:0] W_EBREAK = 32'h0010_0073;
    localparam logic [31:0] W_NOP    = 32'h0000_0013;
    localparam logic [31:0] W_JAL    = 32'h0080_00EF;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] retire;
        logic        wen;
        logic        halt;
        logic        fault;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        ifu_req_valid;
    logic        ifu_req_ready;
    logic [31:0] ifu_addr;
    logic        ifu_resp_valid;
    logic [31:0] ifu_rdata;
    logic [31:0] instruction;
    logic [31:0] pc;
    logic [31:0] next_pc;
    logic        wen;
    logic        halt;
    logic        fault;
    logic [31:0] retire_cnt;

    int testsRun = 0;
    int testsFailed = 0;

    exp_t        sbQ[$];
    logic [31:0] progQ[$];
    logic [31:0] modelPc;
    logic [31:0] modelRetire;
    int          wenExp, wenSeen;

    int          readyDelay, respDelay, lateResp;
    bit          memDrop, junkOnAccept;
    bit          npcOverrideEn;
    logic [31:0] npcOverride;
    int          stallCnt, respWait, acceptCount, reqValidCycles, firstReqCycles, addrChanges;
    bit          respPending;

    logic [31:0] prevRetire;
    logic        lastWen;

    npc_exec_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .ifu_req_valid (ifu_req_valid),
        .ifu_req_ready (ifu_req_ready),
        .ifu_addr      (ifu_addr),
        .ifu_resp_valid(ifu_resp_valid),
        .ifu_rdata     (ifu_rdata),
        .instruction   (instruction),
        .pc            (pc),
        .next_pc       (next_pc),
        .wen           (wen),
        .halt          (halt),
        .fault         (fault),
        .retire_cnt    (retire_cnt)
    );

    always #5 clk = ~clk;

    // Datapath stand-in: sequential next PC unless a test forces a jump target.
    assign next_pc = npcOverrideEn ? npcOverride : pc + 32'd4;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    function automatic logic expWen(input logic [31:0] w);
        logic [6:0] op;
        op = w[6:0];
        if (w == W_EBREAK) return 1'b0;
        return (op == 7'h6F) || (op == 7'h67) || (op == 7'h17) || (op == 7'h37) || (op == 7'h13);
    endfunction

    task automatic pushExpect(input logic [31:0] word);
        exp_t e;
        e.wen   = expWen(word);
        e.halt  = (word == W_EBREAK);
        e.fault = 1'b0;
        if (word != W_EBREAK) modelPc = npcOverrideEn ? npcOverride : modelPc + 32'd4;
        modelRetire = modelRetire + 32'd1;
        e.pc     = modelPc;
        e.retire = modelRetire;
        if (e.wen) wenExp++;
        sbQ.push_back(e);
    endtask

    task automatic clearModel();
        sbQ.delete();
        progQ.delete();
        modelPc        = RESET_PC;
        modelRetire    = '0;
        wenExp         = 0;
        wenSeen        = 0;
        readyDelay     = 0;
        respDelay      = 0;
        lateResp       = 0;
        memDrop        = 1'b0;
        junkOnAccept   = 1'b0;
        npcOverrideEn  = 1'b0;
        npcOverride    = '0;
        acceptCount    = 0;
        reqValidCycles = 0;
        firstReqCycles = 0;
        addrChanges    = 0;
    endtask

    task automatic applyReset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        clearModel();
    endtask

    task automatic applyStimulus(input logic [31:0] w0, input logic [31:0] w1, input int nWords);
        if (nWords > 0) progQ.push_back(w0);
        if (nWords > 1) progQ.push_back(w1);
        rst = 1'b0;
    endtask

    task automatic waitHalt(input int limit);
        int n;
        n = 0;
        while (!halt && n < limit) begin
            @(negedge clk);
            #1;
            n++;
        end
        checkOutput("haltReached", {31'd0, halt}, 32'd1);
    endtask

    // Memory responder: stalls ready, returns the next program word after
    // acceptance (optionally delayed or dropped) and records request behaviour.
    initial begin
        logic [31:0] word;
        ifu_req_ready  = 1'b0;
        ifu_resp_valid = 1'b0;
        ifu_rdata      = '0;
        stallCnt       = 0;
        respWait       = 0;
        respPending    = 1'b0;
        forever begin
            @(negedge clk);
            ifu_resp_valid = 1'b0;
            if (rst) begin
                ifu_req_ready = 1'b0;
                stallCnt      = 0;
                respPending   = 1'b0;
                continue;
            end
            if (lateResp > 0) begin
                ifu_resp_valid = 1'b1;
                ifu_rdata      = W_EBREAK;
                lateResp--;
            end
            if (ifu_req_ready) begin
                ifu_req_ready = 1'b0;
                acceptCount++;
                if (acceptCount == 1) firstReqCycles = reqValidCycles;
                respPending = 1'b1;
                respWait    = respDelay;
                stallCnt    = 0;
            end
            if (respPending) begin
                if (respWait > 0) begin
                    respWait--;
                end else begin
                    respPending = 1'b0;
                    if (!memDrop) begin
                        word = (progQ.size() > 0) ? progQ.pop_front() : W_NOP;
                        ifu_resp_valid = 1'b1;
                        ifu_rdata      = word;
                        pushExpect(word);
                    end
                end
            end else if (ifu_req_valid) begin
                reqValidCycles++;
                if (ifu_addr != modelPc) addrChanges++;
                if (stallCnt < readyDelay) begin
                    stallCnt++;
                end else begin
                    ifu_req_ready = 1'b1;
                    if (junkOnAccept) begin
                        ifu_resp_valid = 1'b1;
                        ifu_rdata      = W_EBREAK;
                    end
                end
            end
        end
    end

    // Commit monitor: every retire_cnt change pops one scoreboard entry; wen is
    // taken from the previous sample, which is the EXEC cycle.
    initial begin
        exp_t e;
        prevRetire = '0;
        lastWen    = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (wen) wenSeen++;
                if (retire_cnt != prevRetire) begin
                    checkOutput("sbDepth", {31'd0, (sbQ.size() != 0)}, 32'd1);
                    if (sbQ.size() != 0) begin
                        e = sbQ.pop_front();
                        checkOutput("commitPc", pc, e.pc);
                        checkOutput("commitRetire", retire_cnt, e.retire);
                        checkOutput("commitWen", {31'd0, lastWen}, {31'd0, e.wen});
                        checkOutput("commitHalt", {31'd0, halt}, {31'd0, e.halt});
                        checkOutput("commitFault", {31'd0, fault}, {31'd0, e.fault});
                    end
                end
            end
            prevRetire = retire_cnt;
            lastWen    = wen;
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n, lat, snap;
        rst = 1'b1;
        clearModel();

        // Reset values
        applyReset();
        checkOutput("rstPc", pc, RESET_PC);
        checkOutput("rstInstr", instruction, W_NOP);
        checkOutput("rstReqValid", {31'd0, ifu_req_valid}, 32'd0);
        checkOutput("rstWen", {31'd0, wen}, 32'd0);
        checkOutput("rstHalt", {31'd0, halt}, 32'd0);
        checkOutput("rstFault", {31'd0, fault}, 32'd0);
        checkOutput("rstRetire", retire_cnt, 32'd0);

        // addi then ebreak, memory always ready, response next cycle
        applyStimulus(W_ADDI, W_EBREAK, 2);
        n = 0;
        while (!ifu_req_valid && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        checkOutput("firstAddr", ifu_addr, RESET_PC);
        lat = 0;
        while (retire_cnt != 32'd1 && lat < 20) begin
            @(negedge clk);
            #1;
            lat++;
        end
        checkOutput("latency", lat, 32'd3);
        checkOutput("pcAfterAddi", pc, 32'h8000_0004);
        waitHalt(100);
        checkOutput("ebkFault", {31'd0, fault}, 32'd0);
        checkOutput("ebkPc", pc, 32'h8000_0004);
        checkOutput("ebkRetire", retire_cnt, 32'd2);
        snap = reqValidCycles;
        repeat (20) @(negedge clk);
        #1;
        checkOutput("haltNoReq", reqValidCycles - snap, 32'd0);
        checkOutput("wenCount1", wenSeen, wenExp);
        checkOutput("sbEmpty1", sbQ.size(), 32'd0);
        checkOutput("addrStable1", addrChanges, 32'd0);

        // Ready stalled 4 cycles, junk response on the accept cycle
        applyReset();
        readyDelay   = 4;
        junkOnAccept = 1'b1;
        applyStimulus(W_ADDI, W_EBREAK, 2);
        waitHalt(200);
        checkOutput("stallReqCycles", firstReqCycles, 32'd5);
        checkOutput("stallAddrStable", addrChanges, 32'd0);
        checkOutput("stallFault", {31'd0, fault}, 32'd0);
        checkOutput("stallRetire", retire_cnt, 32'd2);
        checkOutput("stallInstr", instruction, W_EBREAK);
        checkOutput("sbEmpty2", sbQ.size(), 32'd0);

        // JAL to a misaligned target faults at the next fetch
        applyReset();
        npcOverrideEn = 1'b1;
        npcOverride   = 32'h8000_0102;
        applyStimulus(W_JAL, W_NOP, 1);
        waitHalt(100);
        checkOutput("jalFault", {31'd0, fault}, 32'd1);
        checkOutput("jalPc", pc, 32'h8000_0102);
        checkOutput("jalRetire", retire_cnt, 32'd1);
        checkOutput("jalReqCycles", reqValidCycles, 32'd1);
        checkOutput("jalWenCount", wenSeen, wenExp);
        checkOutput("sbEmpty3", sbQ.size(), 32'd0);

        // No response: timeout after 16 WAIT cycles, late response ignored
        applyReset();
        memDrop = 1'b1;
        applyStimulus(W_ADDI, W_NOP, 1);
        n = 0;
        while (acceptCount == 0 && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        n = 0;
        while (!halt && n < 40) begin
            @(negedge clk);
            #1;
            n++;
        end
        checkOutput("timeoutCycles", n, 32'd16);
        checkOutput("timeoutFault", {31'd0, fault}, 32'd1);
        checkOutput("timeoutHalt", {31'd0, halt}, 32'd1);
        lateResp = 2;
        repeat (4) @(negedge clk);
        #1;
        checkOutput("lateInstr", instruction, W_NOP);
        checkOutput("lateRetire", retire_cnt, 32'd0);
        checkOutput("lateFault", {31'd0, fault}, 32'd1);
        checkOutput("lateWen", wenSeen, 32'd0);

        // Reset during WAIT with a response arriving the same cycle
        applyReset();
        applyStimulus(W_ADDI, W_ADDI, 2);
        n = 0;
        while (retire_cnt != 32'd1 && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        respDelay = 1;
        n = 0;
        while (!(acceptCount == 2 && ifu_resp_valid) && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        checkOutput("preRstInstr", instruction, W_ADDI);
        checkOutput("preRstPc", pc, 32'h8000_0004);
        rst = 1'b1;
        @(negedge clk);
        #1;
        checkOutput("midRstPc", pc, RESET_PC);
        checkOutput("midRstInstr", instruction, W_NOP);
        checkOutput("midRstRetire", retire_cnt, 32'd0);
        checkOutput("midRstIdle", {31'd0, ifu_req_valid}, 32'd0);
        clearModel();
        applyStimulus(W_EBREAK, W_NOP, 1);
        @(negedge clk);
        #1;
        checkOutput("postRstReq", {31'd0, ifu_req_valid}, 32'd1);
        checkOutput("postRstAddr", ifu_addr, RESET_PC);
        waitHalt(100);
        checkOutput("postRstPc", pc, RESET_PC);
        checkOutput("postRstRetire", retire_cnt, 32'd1);
        checkOutput("postRstFault", {31'd0, fault}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
